// File: rtl/var_bw_mul_pkg.sv
// Shared definitions for the variable bit-width multiplier scheduler.
// Holds operand/product widths, the requester class enum used for
// round-robin arbitration, and the tag carried alongside each issue
// through the multiplier latency.
package var_bw_mul_pkg;

   localparam int W16 = 16;
   localparam int W8  = 8;
   localparam int WP  = 32;

   // Requester class that received the most recent grant
   typedef enum logic {
      CLS_16 = 1'b0,
      CLS_8  = 1'b1
   } cls_e;

   // One in-flight op: valid, parallel mode, and which lanes it serves
   typedef struct packed {
      logic vld;
      logic para;
      logic l0;
      logic l1;
   } tag_t;

endpackage

// File: rtl/var_bw_mul_sched_if.sv
// Bus bundle for var_bw_mul_sched.
// Carries the three request handshakes (16-bit port, 8-bit lanes 0/1),
// the issue path toward the shared multiplier, the product return,
// the per-requester responses and the packed-issue counter.
// slave  : the scheduler's view (takes requests, drives issue/responses)
// master : the environment's view (requesters plus multiplier)
interface var_bw_mul_sched_if;
   import var_bw_mul_pkg::*;

   logic           en;
   logic           r16_vld;
   logic           r16_rdy;
   logic [W16-1:0] r16_a;
   logic [W16-1:0] r16_b;
   logic           r0_vld;
   logic           r0_rdy;
   logic [W8-1:0]  r0_a;
   logic [W8-1:0]  r0_b;
   logic           r1_vld;
   logic           r1_rdy;
   logic [W8-1:0]  r1_a;
   logic [W8-1:0]  r1_b;
   logic           mul_vld;
   logic           mul_para_mode;
   logic [W16-1:0] mul_a;
   logic [W16-1:0] mul_b;
   logic [WP-1:0]  mul_p;
   logic           rsp16_vld;
   logic [WP-1:0]  rsp16_p;
   logic           rsp0_vld;
   logic [W16-1:0] rsp0_p;
   logic           rsp1_vld;
   logic [W16-1:0] rsp1_p;
   logic [15:0]    cnt_pair;

   modport slave (
      input  en, r16_vld, r16_a, r16_b, r0_vld, r0_a, r0_b,
             r1_vld, r1_a, r1_b, mul_p,
      output r16_rdy, r0_rdy, r1_rdy, mul_vld, mul_para_mode, mul_a, mul_b,
             rsp16_vld, rsp16_p, rsp0_vld, rsp0_p, rsp1_vld, rsp1_p, cnt_pair
   );

   modport master (
      output en, r16_vld, r16_a, r16_b, r0_vld, r0_a, r0_b,
             r1_vld, r1_a, r1_b, mul_p,
      input  r16_rdy, r0_rdy, r1_rdy, mul_vld, mul_para_mode, mul_a, mul_b,
             rsp16_vld, rsp16_p, rsp0_vld, rsp0_p, rsp1_vld, rsp1_p, cnt_pair
   );

endinterface

// File: rtl/var_bw_mul_tag_pipe.sv
// Tag delay line that follows each issue through the multiplier.
// Ports: clk, rst (synchronous clear of every stage), tag_in (tag of
// the op issued next cycle), tag_out (tag whose product is on mul_p now).
module var_bw_mul_tag_pipe
   import var_bw_mul_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t stage [DEPTH];

   // Plain shift register; a reset wipes every stage so ops already in
   // flight can never surface as responses afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/var_bw_mul_sched.sv
// Issue scheduler for the shared variable bit-width multiplier.
// Ports: clk, rst (sync, active-high), bus (slave side of
// var_bw_mul_sched_if: three request handshakes, multiplier issue/product,
// per-requester responses, cnt_pair).
// Lane 0/1 requests are packed into one parallel-mode issue when both are
// present; a lone lane waits up to PACK_WAIT cycles for a partner. The
// 16-bit and 8-bit classes alternate when both are eligible.
module var_bw_mul_sched
   import var_bw_mul_pkg::*;
#(
   parameter int MUL_LAT   = 0,
   parameter int PACK_WAIT = 2
) (
   input  logic clk,
   input  logic rst,
   var_bw_mul_sched_if.slave bus
);

   localparam int WCW = (PACK_WAIT < 1) ? 1 : $clog2(PACK_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(PACK_WAIT);

   cls_e           last_class;
   cls_e           last_class_nxt;
   logic [WCW-1:0] wcnt;
   logic [WCW-1:0] wcnt_nxt;
   logic           grant16;
   logic           grant8;
   logic           lane_any;
   logic           lane_one;
   logic           lane_two;
   logic           elig16;
   logic           elig8;
   logic [W8-1:0]  lane0_a;
   logic [W8-1:0]  lane0_b;
   logic [W8-1:0]  lane1_a;
   logic [W8-1:0]  lane1_b;
   tag_t           tag_in;
   tag_t           tail;

   logic           mul_vld_q;
   logic           para_q;
   logic [W16-1:0] a_q;
   logic [W16-1:0] b_q;
   logic [15:0]    cnt_pair_q;
   logic           rsp16_vld_q;
   logic [WP-1:0]  rsp16_p_q;
   logic           rsp0_vld_q;
   logic [W16-1:0] rsp0_p_q;
   logic           rsp1_vld_q;
   logic [W16-1:0] rsp1_p_q;

   assign lane_any = bus.r0_vld | bus.r1_vld;
   assign lane_one = bus.r0_vld ^ bus.r1_vld;
   assign lane_two = bus.r0_vld & bus.r1_vld;
   assign elig16   = bus.r16_vld;
   assign elig8    = lane_two | (lane_one & (wcnt == WAIT_MAX));

   // Unused half of a parallel issue is forced to zero.
   assign lane0_a = bus.r0_vld ? bus.r0_a : 8'h00;
   assign lane0_b = bus.r0_vld ? bus.r0_b : 8'h00;
   assign lane1_a = bus.r1_vld ? bus.r1_a : 8'h00;
   assign lane1_b = bus.r1_vld ? bus.r1_b : 8'h00;

   // Arbitration state: which class won last, and how long a lone lane
   // has been waiting for a partner.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_class <= CLS_8;
         wcnt       <= '0;
      end else begin
         last_class <= last_class_nxt;
         wcnt       <= wcnt_nxt;
      end
   end

   // Next arbitration state. The wait counter is frozen while grants are
   // disabled so a lone lane does not age while the scheduler is paused.
   always_comb begin
      last_class_nxt = last_class;
      wcnt_nxt       = wcnt;
      if (grant16) begin
         last_class_nxt = CLS_16;
      end else if (grant8) begin
         last_class_nxt = CLS_8;
      end
      if (bus.en) begin
         if (grant8 || !lane_any) begin
            wcnt_nxt = '0;
         end else if (lane_one && (wcnt != WAIT_MAX)) begin
            wcnt_nxt = wcnt + WCW'(1);
         end
      end
   end

   // Grant decision: a lone eligible class wins outright, a tie goes to
   // the class that did not win last time.
   always_comb begin
      grant16 = 1'b0;
      grant8  = 1'b0;
      if (bus.en && !rst) begin
         if (elig16 && elig8) begin
            if (last_class == CLS_8) begin
               grant16 = 1'b1;
            end else begin
               grant8 = 1'b1;
            end
         end else if (elig16) begin
            grant16 = 1'b1;
         end else if (elig8) begin
            grant8 = 1'b1;
         end
      end
   end

   assign bus.r16_rdy = grant16;
   assign bus.r0_rdy  = grant8 & bus.r0_vld;
   assign bus.r1_rdy  = grant8 & bus.r1_vld;

   assign tag_in.vld  = grant16 | grant8;
   assign tag_in.para = grant8;
   assign tag_in.l0   = grant8 & bus.r0_vld;
   assign tag_in.l1   = grant8 & bus.r1_vld;

   // Issue register: operands captured on the accept cycle and presented
   // to the multiplier the following cycle; held when nothing issues.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_vld_q  <= 1'b0;
         para_q     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         cnt_pair_q <= '0;
      end else begin
         mul_vld_q <= grant16 | grant8;
         if (grant16) begin
            para_q <= 1'b0;
            a_q    <= bus.r16_a;
            b_q    <= bus.r16_b;
         end else if (grant8) begin
            para_q <= 1'b1;
            a_q    <= {lane1_a, lane0_a};
            b_q    <= {lane1_b, lane0_b};
         end
         if (grant8 && lane_two && (cnt_pair_q != 16'hFFFF)) begin
            cnt_pair_q <= cnt_pair_q + 16'd1;
         end
      end
   end

   var_bw_mul_tag_pipe #(
      .DEPTH (MUL_LAT + 1)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tail)
   );

   // Response capture: the tag leaving the pipe says whose product is on
   // mul_p this cycle; result registers hold between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp16_vld_q <= 1'b0;
         rsp16_p_q   <= '0;
         rsp0_vld_q  <= 1'b0;
         rsp0_p_q    <= '0;
         rsp1_vld_q  <= 1'b0;
         rsp1_p_q    <= '0;
      end else begin
         rsp16_vld_q <= tail.vld & ~tail.para;
         rsp0_vld_q  <= tail.vld & tail.para & tail.l0;
         rsp1_vld_q  <= tail.vld & tail.para & tail.l1;
         if (tail.vld && !tail.para) begin
            rsp16_p_q <= bus.mul_p;
         end
         if (tail.vld && tail.para && tail.l0) begin
            rsp0_p_q <= bus.mul_p[W16-1:0];
         end
         if (tail.vld && tail.para && tail.l1) begin
            rsp1_p_q <= bus.mul_p[WP-1:W16];
         end
      end
   end

   assign bus.mul_vld       = mul_vld_q;
   assign bus.mul_para_mode = para_q;
   assign bus.mul_a         = a_q;
   assign bus.mul_b         = b_q;
   assign bus.cnt_pair      = cnt_pair_q;
   assign bus.rsp16_vld     = rsp16_vld_q;
   assign bus.rsp16_p       = rsp16_p_q;
   assign bus.rsp0_vld      = rsp0_vld_q;
   assign bus.rsp0_p        = rsp0_p_q;
   assign bus.rsp1_vld      = rsp1_vld_q;
   assign bus.rsp1_p        = rsp1_p_q;

endmodule
